// File: rtl/serial_mod_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_mod_pkg
// Brief    : Shared state and mode encodings for the serial modulo checker.
// Revision : 1.0 - initial release
// ============================================================================
package serial_mod_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic MODE_SUM  = 1'b0;
    localparam logic MODE_DIFF = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_mod_step.sv
`default_nettype none
// ============================================================================
// Module   : serial_mod_step
// Brief    : One MSB-first residue step: r_next = (2*r + d) mod MOD, d = x+/-y.
// Revision : 1.0 - initial release
// ============================================================================
module serial_mod_step
    import serial_mod_pkg::*;
#(
    parameter  int MOD = 4,
    localparam int RW  = $clog2(MOD)
) (
    input  logic [RW-1:0] r,
    input  logic          x,
    input  logic          y,
    input  logic          mode,
    output logic [RW-1:0] r_next
);

    // One extra bit of headroom: with a power-of-two MOD, 2r+2 reaches 2^(RW+1).
    localparam int          TW     = RW + 3;
    localparam logic [TW-1:0] c_mod  = TW'(MOD);
    localparam logic [TW-1:0] c_mod2 = TW'(2 * MOD);

    logic [TW-1:0] w_xe;
    logic [TW-1:0] w_ye;
    logic [TW-1:0] w_d;
    logic [TW-1:0] w_t;
    logic [TW-1:0] w_red;
    logic          w_unused_hi;

    assign w_xe = TW'(x);
    assign w_ye = TW'(y);
    assign w_d  = (mode == MODE_DIFF) ? (w_xe - w_ye) : (w_xe + w_ye);
    assign w_t  = {1'b0, r, 1'b0} + w_d;

    always_comb begin
        w_red = w_t;
        if (w_t[TW-1]) begin
            w_red = w_t + c_mod;
        end else if (w_t >= c_mod2) begin
            w_red = w_t - c_mod2;
        end else if (w_t >= c_mod) begin
            w_red = w_t - c_mod;
        end
    end

    assign r_next      = w_red[RW-1:0];
    assign w_unused_hi = &{1'b0, w_red[TW-1:RW]};

endmodule
`default_nettype wire

// File: rtl/serial_mod_checker.sv
`default_nettype none
// ============================================================================
// Module   : serial_mod_checker
// Brief    : Framed serial (A+B)/(A-B) mod MOD tracker with divisibility flag.
// Revision : 1.0 - initial release
// ============================================================================
module serial_mod_checker
    import serial_mod_pkg::*;
#(
    parameter  int MOD       = 4,
    parameter  int FRAME_LEN = 16,
    localparam int RW        = $clog2(MOD),
    localparam int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic          x,
    input  logic          y,
    input  logic          mode,
    output logic          z,
    output logic [RW-1:0] residue,
    output logic          frame_done,
    output logic          busy
);

    localparam logic [CW-1:0] c_last_idx = CW'(FRAME_LEN - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic          r_mode_q;
    logic [CW-1:0] r_count;
    logic [RW-1:0] r_residue;
    logic          r_z;
    logic          r_frame_done;

    logic          w_accept;
    logic          w_mode_eff;
    logic [RW-1:0] w_r_base;
    logic [RW-1:0] w_r_next;
    logic [CW-1:0] w_cnt_base;
    logic          w_last;

    // A start cycle behaves as a fresh frame: residue, count and mode restart.
    assign w_accept   = in_valid && ((r_state == S_RUN) || start);
    assign w_mode_eff = start ? mode : r_mode_q;
    assign w_r_base   = start ? '0 : r_residue;
    assign w_cnt_base = start ? '0 : r_count;
    assign w_last     = w_accept && (w_cnt_base == c_last_idx);

    serial_mod_step #(
        .MOD (MOD)
    ) u_step (
        .r      (w_r_base),
        .x      (x),
        .y      (y),
        .mode   (w_mode_eff),
        .r_next (w_r_next)
    );

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = w_last ? S_HOLD : S_RUN;
        end else if (w_last) begin
            w_state_next = S_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_q     <= MODE_SUM;
            r_count      <= '0;
            r_residue    <= '0;
            r_z          <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (start) begin
                r_mode_q  <= mode;
                r_count   <= '0;
                r_residue <= '0;
                r_z       <= 1'b0;
            end
            if (w_accept) begin
                r_residue <= w_r_next;
                r_z       <= (w_r_next == '0);
                r_count   <= w_cnt_base + CW'(1);
            end
            r_frame_done <= w_last;
        end
    end

    assign z          = r_z;
    assign residue    = r_residue;
    assign frame_done = r_frame_done;
    assign busy       = (r_state == S_RUN);

endmodule
`default_nettype wire
